// File: rtl/axi_lite_regbank_pkg.sv
// axi_lite_regbank_pkg
// Shared definitions for the AXI4-Lite register bank: response codes, the
// word-address offset, the write/read FSM state encodings and a byte-lane
// merge helper used when committing a strobed write.
// Optional feature macro used by the files importing this package:
// AXI_REGBANK_STATUS_EN (upper half of the register space becomes read-only
// status inputs).
package axi_lite_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Registers are 32-bit words, so the index starts above the byte offset.
  localparam int ADDR_LSB = 2;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_WAIT_DATA = 2'd1,
    W_WAIT_ADDR = 2'd2,
    W_RESP      = 2'd3
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  // Bytes whose strobe is set take the new value, the rest keep the old one.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_wr_capture.sv
// axi_lite_wr_capture
// Write-side half of the register bank. Accepts the AW and W channels
// independently, holds whichever half arrives first, and raises a commit
// strobe (with decoded index, in-range/writable flag, data and strobes) on the
// edge where the second half is accepted. Also owns the B channel.
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   s_axi_aw*, s_axi_w*  write address / data channels
//   s_axi_b*             write response channel
//   commit               the current edge completes a write
//   commit_ok            target is in range and writable
//   commit_idx/data/strb decoded register index, write data and byte enables
// Macro AXI_REGBANK_STATUS_EN: indices in the upper half are not writable.
module axi_lite_wr_capture
  import axi_lite_regbank_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic                         commit,
  output logic                         commit_ok,
  output logic [$clog2(NUM_REGS)-1:0]  commit_idx,
  output logic [31:0]                  commit_data,
  output logic [3:0]                   commit_strb
);

  localparam int IDX_W = $clog2(NUM_REGS);

  wr_state_e             state;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic [3:0]            strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  have_aw;
  logic                  have_w;
  logic                  in_range;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign aw_hs   = s_axi_awvalid & awready_q;
  assign w_hs    = s_axi_wvalid & wready_q;
  assign have_aw = aw_hs | (state == W_WAIT_DATA);
  assign have_w  = w_hs | (state == W_WAIT_ADDR);
  assign commit  = have_aw & have_w;

  // A held half comes from the capture registers, a fresh one straight
  // from the bus, so a same-cycle AW+W pair commits without extra latency.
  assign cur_addr    = (state == W_WAIT_DATA) ? addr_q : s_axi_awaddr;
  assign commit_data = (state == W_WAIT_ADDR) ? data_q : s_axi_wdata;
  assign commit_strb = (state == W_WAIT_ADDR) ? strb_q : s_axi_wstrb;
  assign commit_idx  = cur_addr[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign in_range    = (cur_addr >> (IDX_W + ADDR_LSB)) == '0;

`ifdef AXI_REGBANK_STATUS_EN
  assign commit_ok = in_range & ~commit_idx[IDX_W-1];
`else
  assign commit_ok = in_range;
`endif

  // Write FSM: the state doubles as the "address held"/"data held" flags,
  // readies are registered so they rise one edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      case (state)
        W_IDLE, W_WAIT_DATA, W_WAIT_ADDR: begin
          if (aw_hs) begin
            addr_q <= s_axi_awaddr;
          end
          if (w_hs) begin
            data_q <= s_axi_wdata;
            strb_q <= s_axi_wstrb;
          end
          if (commit) begin
            state     <= W_RESP;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= commit_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (have_aw) begin
            state     <= W_WAIT_DATA;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (have_w) begin
            state     <= W_WAIT_ADDR;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            state     <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            state     <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: state <= W_IDLE;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: rtl/axi_lite_regbank.sv
// axi_lite_regbank
// AXI4-Lite responder exposing NUM_REGS 32-bit control registers to fabric
// logic in parallel, with a one-cycle write strobe per register.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*    AXI4-Lite write channels (handled by axi_lite_wr_capture)
//   s_axi_ar*/r*       AXI4-Lite read channels
//   status_i           (only with AXI_REGBANK_STATUS_EN) read-only status words
//   reg_q              register i at reg_q[32*i+31:32*i]
//   reg_wr_pulse       bit i high for one cycle when register i is written
// Macro AXI_REGBANK_STATUS_EN: the upper NUM_REGS/2 indices read status_i,
// reject writes with SLVERR and show 0 on reg_q (requires NUM_REGS >= 4).
module axi_lite_regbank
  import axi_lite_regbank_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [ADDR_WIDTH-1:0]    s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
`ifdef AXI_REGBANK_STATUS_EN
  input  logic [(NUM_REGS/2)*32-1:0] status_i,
`endif
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = $clog2(NUM_REGS);
`ifdef AXI_REGBANK_STATUS_EN
  localparam int NUM_RW = NUM_REGS / 2;
`else
  localparam int NUM_RW = NUM_REGS;
`endif
  localparam int RW_W = $clog2(NUM_RW);

  logic             unused_prot;
  logic             commit;
  logic             commit_ok;
  logic [IDX_W-1:0] commit_idx;
  logic [31:0]      commit_data;
  logic [3:0]       commit_strb;
  logic [RW_W-1:0]  wr_rw_idx;

  logic [31:0]      regs_q [NUM_RW];

  rd_state_e        rd_state;
  logic             arready_q;
  logic             rvalid_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [31:0]      rd_word;

  assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

  axi_lite_wr_capture #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_wr_capture (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .commit        (commit),
    .commit_ok     (commit_ok),
    .commit_idx    (commit_idx),
    .commit_data   (commit_data),
    .commit_strb   (commit_strb)
  );

  // Writable indices all sit below NUM_RW, so the low bits address storage.
  assign wr_rw_idx = commit_idx[RW_W-1:0];

  // Register storage and write strobes; a rejected write changes nothing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_RW; i++) begin
        regs_q[i] <= RESET_VALUE;
      end
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && commit_ok) begin
        regs_q[wr_rw_idx]        <= apply_wstrb(regs_q[wr_rw_idx], commit_data, commit_strb);
        reg_wr_pulse[commit_idx] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    if (g < NUM_RW) begin : g_rw
      assign reg_q[32*g +: 32] = regs_q[g];
    end else begin : g_ro
      assign reg_q[32*g +: 32] = '0;
    end
  end

  assign rd_idx      = s_axi_araddr[IDX_W+ADDR_LSB-1:ADDR_LSB];
  assign rd_in_range = (s_axi_araddr >> (IDX_W + ADDR_LSB)) == '0;

`ifdef AXI_REGBANK_STATUS_EN
  logic [NUM_RW-1:0][31:0] status_arr;
  assign status_arr = status_i;
`endif

  // Read data selection; out-of-range addresses return zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
`ifdef AXI_REGBANK_STATUS_EN
      if (rd_idx[IDX_W-1]) begin
        rd_word = status_arr[rd_idx[RW_W-1:0]];
      end else begin
        rd_word = regs_q[rd_idx[RW_W-1:0]];
      end
`else
      rd_word = regs_q[rd_idx];
`endif
    end
  end

  // Read FSM: data is sampled on the AR handshake edge, so a write committing
  // on that same edge is not yet visible in this response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (rd_state == R_IDLE) begin
        if (s_axi_arvalid && arready_q) begin
          rd_state  <= R_RESP;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rd_word;
          rresp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          arready_q <= 1'b1;
        end
      end else if (s_axi_rready) begin
        rd_state  <= R_IDLE;
        arready_q <= 1'b1;
        rvalid_q  <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- AXI4-Lite responder that terminates the processor subsystem's M_AXI peripheral master port, which is currently tied off in the system top.
- Provides NUM_REGS 32-bit read/write control registers, driven in parallel to fabric logic, plus one-cycle write strobes per register.
- Instantiated in the system top beside the MII-to-RMII bridge; the interconnect decodes the base address upstream.

Parameters:
- ADDR_WIDTH, 32: AXI address width.
- NUM_REGS, 16: number of 32-bit registers; power of two, 2..256.
- RESET_VALUE, 32'h00000000: reset value loaded into every register.

Ports:
- clk  input  1  AXI/system clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- s_axi_awaddr  input  ADDR_WIDTH  write address.
- s_axi_awprot  input  3  ignored.
- s_axi_awvalid / s_axi_awready  input / output  1  write address handshake.
- s_axi_wdata  input  32  write data.
- s_axi_wstrb  input  4  byte enables.
- s_axi_wvalid / s_axi_wready  input / output  1  write data handshake.
- s_axi_bresp  output  2  write response.
- s_axi_bvalid / s_axi_bready  output / input  1  write response handshake.
- s_axi_araddr  input  ADDR_WIDTH  read address.
- s_axi_arprot  input  3  ignored.
- s_axi_arvalid / s_axi_arready  input / output  1  read address handshake.
- s_axi_rdata  output  32  read data.
- s_axi_rresp  output  2  read response.
- s_axi_rvalid / s_axi_rready  output / input  1  read data handshake.
- reg_q  output  NUM_REGS*32  register contents; register i is reg_q[32*i+31:32*i].
- reg_wr_pulse  output  NUM_REGS  one-cycle strobe, bit i set when register i is written.

Behaviour:
- Reset (async assert, sync release):
  - All readies, bvalid, rvalid and reg_wr_pulse are 0.
  - bresp, rresp and rdata are 0.
  - Every register holds RESET_VALUE.
  - awready and arready rise on the first clk edge after resetn deasserts.
- Decode:
  - Index = addr[IDX_W+1:2], with IDX_W = log2(NUM_REGS).
  - addr[1:0] is ignored. Bits above IDX_W+1 are ignored by the index.
  - If addr[ADDR_WIDTH-1:IDX_W+2] is nonzero: SLVERR (2'b10), no write, and rdata = 0.
  - Otherwise: OKAY (2'b00).
- Write FSM, states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP:
  - AW and W are accepted independently. awready is high only when no address is held and bvalid=0; wready likewise for data.
  - AW alone -> W_WAIT_DATA. W alone -> W_WAIT_ADDR. Both handshakes in the same cycle, or the missing half arriving -> commit.
  - Commit at the edge after both halves are held (latency 1 from the last handshake):
    - Register bytes with wstrb=1 update; other bytes are held.
    - reg_wr_pulse[i]=1 for exactly that cycle.
    - bvalid=1 and bresp is set; state -> W_RESP.
  - A write with wstrb=0 still pulses reg_wr_pulse and returns OKAY.
  - W_RESP: bvalid, bresp and the register contents stay stable until bready. On the bready handshake -> W_IDLE, with awready/wready high the next cycle.
  - Back-to-back throughput: one write per 2 cycles when bready is held at 1.
- Read FSM, states R_IDLE, R_RESP:
  - arready=1 only in R_IDLE.
  - An AR handshake at edge N gives rvalid=1 with rdata/rresp valid after edge N; state -> R_RESP.
  - rdata is sampled at edge N, so a write committing at that same edge is not visible.
  - rdata, rresp and rvalid are held until rready; then -> R_IDLE.
  - One read per 2 cycles.
- Read and write channels are fully independent; simultaneous read and write to the same register in one cycle is legal and follows the sampling rule above.
- Reset asserted mid-transaction:
  - Any outstanding transaction is dropped with no response.
  - Registers return to RESET_VALUE.
  - The master is expected to be reset together with this block.

Optional Feature:
- Macro: AXI_REGBANK_STATUS_EN.
- When defined:
  - Adds input port status_i, width (NUM_REGS/2)*32.
  - The upper half of the index space (i >= NUM_REGS/2) becomes read-only: reads return status_i slice i-NUM_REGS/2.
  - Writes to those indices return SLVERR, with no reg_wr_pulse and no state change.
  - reg_q for those slices reads 0.
- When undefined: all NUM_REGS registers are read/write and status_i does not exist.

Decomposition:
- Shared package/include holds: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ADDR_LSB=2, and the state encodings for the W and R FSMs.
- One natural sub-module: axi_lite_wr_capture. It holds the AW/W half-transaction registers and the address/data valid flags, and emits a commit strobe with the decoded index and the in-range flag.

Test Plan:
- After reset with NUM_REGS=16: read addr 0x08 -> rdata=0x00000000, rresp=OKAY; awready=arready=1 one cycle after resetn rises.
- AW 0x04 and W 0xDEADBEEF in the same cycle with wstrb=4'hF -> next cycle bvalid=1, bresp=OKAY, reg_wr_pulse=16'h0002, reg_q[63:32]=0xDEADBEEF.
- W 0x12345678 with wstrb=4'b0101 to addr 0x04 first, AW three cycles later -> reg1=0xDE34BE78; bvalid is held 5 cycles while bready=0 and drops the cycle after bready.
- Write to addr 0x40 (out of range for 16 regs) -> bresp=SLVERR, no pulse, no register change; read of 0x40 -> rresp=SLVERR, rdata=0.
- AR 0x0C and commit of a write 0xA5A5A5A5 to 0x0C at the same edge -> rdata = old value; a following read returns 0xA5A5A5A5.
- With AXI_REGBANK_STATUS_EN, status slice 0=0xCAFEF00D: read 0x20 -> 0xCAFEF00D; write 0x20 -> SLVERR.
